// File: rtl/ahblite_pkg.sv
// Shared types and encodings for the AHB-Lite master address/data-phase stage.
package ahblite_pkg;

   localparam int NUM_SLOTS = 17;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      DP_IDLE,
      DP_SLAVE,
      DP_ERR1,
      DP_ERR2
   } dp_state_t;

   // Index of the set bit of a one-hot slot vector; the lowest set bit wins if several are set.
   function automatic logic [4:0] onehot_to_idx(input logic [NUM_SLOTS-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (v[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: the two-cycle ERROR response (ERR1 stalls, ERR2 completes) for
// unmapped, reserved or disabled slots.
module ahblite_default_slave
   import ahblite_pkg::*;
(
   input  dp_state_t state_i,
   output logic      ready_o,
   output logic      resp_o,
   output dp_state_t next_o
);

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      ready_o = 1'b1;
      resp_o  = HRESP_OKAY;
      next_o  = DP_ERR1;
      unique case (state_i)
         DP_ERR1: begin
            ready_o = 1'b0;
            resp_o  = HRESP_ERROR;
            next_o  = DP_ERR2;
         end
         DP_ERR2: begin
            resp_o  = HRESP_ERROR;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ahblite_master_dp_stage.sv
// Single-master AHB-Lite address/data-phase stage: HSEL generation, slave broadcast,
// registered data-phase slot and response mux, with an embedded default slave.
module ahblite_master_dp_stage
   import ahblite_pkg::*;
#(
   parameter logic [NUM_SLOTS-1:0] M_AHBSLOTENABLE = 17'h1FFFF
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic [31:0]             HADDRM,
   input  logic [1:0]              HTRANSM,
   input  logic                    HWRITEM,
   input  logic [2:0]              HSIZEM,
   input  logic [2:0]              HBURSTM,
   input  logic [3:0]              HPROTM,
   input  logic                    HMASTLOCKM,
   input  logic [31:0]             HWDATAM,
   output logic                    HREADYM,
   output logic                    HRESPM,
   output logic [31:0]             HRDATAM,
   output logic [31:0]             DEC_ADDR,
   input  logic [NUM_SLOTS-1:0]    ADDRDEC,
   input  logic [31:0]             ABSOLUTEADDR,
   input  logic                    RESERVEDDEC,
   output logic [NUM_SLOTS-1:0]    HSELS,
   output logic [31:0]             HADDRS,
   output logic [1:0]              HTRANSS,
   output logic                    HWRITES,
   output logic [2:0]              HSIZES,
   output logic [2:0]              HBURSTS,
   output logic [3:0]              HPROTS,
   output logic                    HMASTLOCKS,
   output logic [31:0]             HWDATAS,
   output logic                    HREADYS,
   input  logic [NUM_SLOTS-1:0]    HREADYOUTS,
   input  logic [NUM_SLOTS-1:0]    HRESPS,
   input  logic [NUM_SLOTS*32-1:0] HRDATAS
);

   dp_state_t            state_q, state_d;
   logic [4:0]           dp_slot_q, dp_slot_d;
   logic                 active, valid_hit, def_hit, hready_m;
   logic [NUM_SLOTS-1:0] sel_en;
   logic [31:0]          rdata_arr [NUM_SLOTS];
   logic                 ds_ready, ds_resp;
   dp_state_t            ds_next;

   assign active    = HTRANSM[1];
   assign sel_en    = ADDRDEC & M_AHBSLOTENABLE;
   assign valid_hit = active && !RESERVEDDEC && (sel_en != '0);
   assign def_hit   = active && (RESERVEDDEC || (sel_en == '0));

   assign HSELS      = active ? sel_en : '0;
   assign DEC_ADDR   = HADDRM;
   assign HADDRS     = ABSOLUTEADDR;
   assign HTRANSS    = HTRANSM;
   assign HWRITES    = HWRITEM;
   assign HSIZES     = HSIZEM;
   assign HBURSTS    = HBURSTM;
   assign HPROTS     = HPROTM;
   assign HMASTLOCKS = HMASTLOCKM;
   assign HWDATAS    = HWDATAM;
   assign HREADYS    = hready_m;
   assign HREADYM    = hready_m;

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) rdata_arr[i] = HRDATAS[32*i +: 32];
   end

   ahblite_default_slave u_default_slave (
      .state_i (state_q),
      .ready_o (ds_ready),
      .resp_o  (ds_resp),
      .next_o  (ds_next)
   );

   always_comb begin
      hready_m = 1'b1;
      HRESPM   = HRESP_OKAY;
      HRDATAM  = '0;
      unique case (state_q)
         DP_SLAVE: begin
            hready_m = HREADYOUTS[dp_slot_q];
            HRESPM   = HRESPS[dp_slot_q];
            HRDATAM  = rdata_arr[dp_slot_q];
         end
         DP_ERR1, DP_ERR2: begin
            hready_m = ds_ready;
            HRESPM   = ds_resp;
         end
         default: ;
      endcase
   end

   // ERR1 advances unconditionally; everything else samples the address only when HREADYM is high.
   always_comb begin
      state_d   = state_q;
      dp_slot_d = dp_slot_q;
      if (state_q == DP_ERR1) begin
         state_d = ds_next;
      end else if (hready_m) begin
         if (valid_hit) begin
            state_d   = DP_SLAVE;
            dp_slot_d = onehot_to_idx(sel_en);
         end else if (def_hit) begin
            state_d = ds_next;
         end else begin
            state_d = DP_IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= DP_IDLE;
         dp_slot_q <= '0;
      end else begin
         state_q   <= state_d;
         dp_slot_q <= dp_slot_d;
      end
   end

endmodule

// File: tb/tb_ahblite_master_dp_stage.sv
// Directed self-checking bench for ahblite_master_dp_stage; a second instance has the huge slot disabled.
module tb_ahblite_master_dp_stage;
   import ahblite_pkg::*;

   logic                    HCLK, HRESET;
   logic [31:0]             HADDRM, HWDATAM, ABSOLUTEADDR;
   logic [1:0]              HTRANSM;
   logic                    HWRITEM, HMASTLOCKM, RESERVEDDEC;
   logic [2:0]              HSIZEM, HBURSTM;
   logic [3:0]              HPROTM;
   logic [NUM_SLOTS-1:0]    ADDRDEC, HREADYOUTS, HRESPS;
   logic [NUM_SLOTS*32-1:0] HRDATAS;

   logic                    HREADYM, HRESPM, HWRITES, HMASTLOCKS, HREADYS;
   logic [31:0]             HRDATAM, DEC_ADDR, HADDRS, HWDATAS;
   logic [NUM_SLOTS-1:0]    HSELS;
   logic [1:0]              HTRANSS;
   logic [2:0]              HSIZES, HBURSTS;
   logic [3:0]              HPROTS;

   logic                    d_HREADYM, d_HRESPM, d_HWRITES, d_HMASTLOCKS, d_HREADYS;
   logic [31:0]             d_HRDATAM, d_DEC_ADDR, d_HADDRS, d_HWDATAS;
   logic [NUM_SLOTS-1:0]    d_HSELS;
   logic [1:0]              d_HTRANSS;
   logic [2:0]              d_HSIZES, d_HBURSTS;
   logic [3:0]              d_HPROTS;

   int n_checks = 0;
   int n_errors = 0;

   ahblite_master_dp_stage u_dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
      .HWDATAM(HWDATAM), .HREADYM(HREADYM), .HRESPM(HRESPM), .HRDATAM(HRDATAM),
      .DEC_ADDR(DEC_ADDR), .ADDRDEC(ADDRDEC), .ABSOLUTEADDR(ABSOLUTEADDR),
      .RESERVEDDEC(RESERVEDDEC), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
      .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
      .HMASTLOCKS(HMASTLOCKS), .HWDATAS(HWDATAS), .HREADYS(HREADYS),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS)
   );

   ahblite_master_dp_stage #(.M_AHBSLOTENABLE(17'h0FFFF)) u_dis (
      .HCLK(HCLK), .HRESET(HRESET), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
      .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
      .HWDATAM(HWDATAM), .HREADYM(d_HREADYM), .HRESPM(d_HRESPM), .HRDATAM(d_HRDATAM),
      .DEC_ADDR(d_DEC_ADDR), .ADDRDEC(ADDRDEC), .ABSOLUTEADDR(ABSOLUTEADDR),
      .RESERVEDDEC(RESERVEDDEC), .HSELS(d_HSELS), .HADDRS(d_HADDRS), .HTRANSS(d_HTRANSS),
      .HWRITES(d_HWRITES), .HSIZES(d_HSIZES), .HBURSTS(d_HBURSTS), .HPROTS(d_HPROTS),
      .HMASTLOCKS(d_HMASTLOCKS), .HWDATAS(d_HWDATAS), .HREADYS(d_HREADYS),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here and checked #1 later.
   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_rdata(input int slot, input logic [31:0] d);
      HRDATAS[slot*32 +: 32] = d;
   endtask

   task automatic drive_addr(input logic [1:0] trans, input logic [16:0] dec, input logic rsv,
                             input logic [31:0] addr);
      HTRANSM      = trans;
      ADDRDEC      = dec;
      RESERVEDDEC  = rsv;
      HADDRM       = addr;
      ABSOLUTEADDR = addr ^ 32'h8000_0000;
   endtask

   initial begin
      HRESET = 1'b1;
      HWRITEM = 1'b0; HSIZEM = 3'b010; HBURSTM = 3'b000; HPROTM = 4'b0011;
      HMASTLOCKM = 1'b0; HWDATAM = 32'h0;
      HREADYOUTS = '1; HRESPS = '0; HRDATAS = '0;
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      next_cycle();
      next_cycle();
      HRESET = 1'b0;

      // Reset while a slot 3 slave is stalling
      drive_addr(HTRANS_NONSEQ, 17'h00008, 1'b0, 32'h0000_3000);
      settle();
      check("slot3_hsel", 32'(HSELS), 32'h00008);
      next_cycle();
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      HREADYOUTS[3] = 1'b0;
      set_rdata(3, 32'h1234_5678);
      settle();
      check("slot3_stall", 32'(HREADYM), 32'd0);
      HRESET = 1'b1;
      next_cycle();
      next_cycle();
      HRESET = 1'b0;
      settle();
      check("rst_hready", 32'(HREADYM), 32'd1);
      check("rst_hresp", 32'(HRESPM), 32'd0);
      check("rst_hrdata", HRDATAM, 32'h0);
      check("rst_state", 32'(u_dut.state_q), 32'(DP_IDLE));
      check("rst_slot", 32'(u_dut.dp_slot_q), 32'd0);
      HREADYOUTS = '1;

      // Read from slot 5 with two wait states
      drive_addr(HTRANS_NONSEQ, 17'h00020, 1'b0, 32'h0000_5004);
      HWDATAM = 32'hA5A5_0005;
      settle();
      check("s5_hsel", 32'(HSELS), 32'h00020);
      check("s5_dec_addr", DEC_ADDR, 32'h0000_5004);
      check("s5_haddrs", HADDRS, 32'h8000_5004);
      check("s5_htranss", 32'(HTRANSS), 32'(HTRANS_NONSEQ));
      check("s5_hwdatas", HWDATAS, 32'hA5A5_0005);
      check("s5_hreadys_addr", 32'(HREADYS), 32'd1);
      next_cycle();
      drive_addr(HTRANS_IDLE, 17'h00020, 1'b0, 32'h0);
      HREADYOUTS[5] = 1'b0;
      settle();
      check("s5_wait1", 32'(HREADYM), 32'd0);
      check("s5_hreadys_wait", 32'(HREADYS), 32'd0);
      check("s5_hsel_idle", 32'(HSELS), 32'h0);
      next_cycle();
      settle();
      check("s5_wait2", 32'(HREADYM), 32'd0);
      next_cycle();
      HREADYOUTS[5] = 1'b1;
      set_rdata(5, 32'hDEAD_BEEF);
      settle();
      check("s5_done", 32'(HREADYM), 32'd1);
      check("s5_rdata", HRDATAM, 32'hDEAD_BEEF);
      check("s5_resp", 32'(HRESPM), 32'd0);
      next_cycle();
      settle();
      check("s5_after_state", 32'(u_dut.state_q), 32'(DP_IDLE));
      check("s5_after_rdata", HRDATAM, 32'h0);

      // Reserved region; address during ERR1 is ignored, NONSEQ in ERR2 is taken
      drive_addr(HTRANS_NONSEQ, '0, 1'b1, 32'hF000_0000);
      settle();
      check("rsv_hsel", 32'(HSELS), 32'h0);
      next_cycle();
      drive_addr(HTRANS_NONSEQ, 17'h00080, 1'b0, 32'h0000_7000);
      set_rdata(7, 32'h7777_7777);
      settle();
      check("rsv_err1_ready", 32'(HREADYM), 32'd0);
      check("rsv_err1_resp", 32'(HRESPM), 32'd1);
      next_cycle();
      drive_addr(HTRANS_NONSEQ, 17'h00004, 1'b0, 32'h0000_2000);
      settle();
      check("rsv_err2_ready", 32'(HREADYM), 32'd1);
      check("rsv_err2_resp", 32'(HRESPM), 32'd1);
      check("rsv_err2_rdata", HRDATAM, 32'h0);
      check("rsv_err2_hsel", 32'(HSELS), 32'h00004);
      next_cycle();
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      set_rdata(2, 32'hCAFE_0002);
      settle();
      check("s2_ready", 32'(HREADYM), 32'd1);
      check("s2_resp", 32'(HRESPM), 32'd0);
      check("s2_rdata", HRDATAM, 32'hCAFE_0002);
      check("s2_slot", 32'(u_dut.dp_slot_q), 32'd2);
      next_cycle();

      // Huge slot: enabled on u_dut, disabled on u_dis
      drive_addr(HTRANS_NONSEQ, 17'h10000, 1'b0, 32'h4000_0000);
      settle();
      check("huge_hsel_en", 32'(HSELS), 32'h10000);
      check("huge_hsel_dis", 32'(d_HSELS), 32'h0);
      next_cycle();
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      set_rdata(16, 32'h1616_1616);
      settle();
      check("huge_en_rdata", HRDATAM, 32'h1616_1616);
      check("huge_en_slot", 32'(u_dut.dp_slot_q), 32'd16);
      check("huge_dis_err1_ready", 32'(d_HREADYM), 32'd0);
      check("huge_dis_err1_resp", 32'(d_HRESPM), 32'd1);
      next_cycle();
      settle();
      check("huge_dis_err2_ready", 32'(d_HREADYM), 32'd1);
      check("huge_dis_err2_resp", 32'(d_HRESPM), 32'd1);
      next_cycle();
      settle();
      check("huge_dis_done_resp", 32'(d_HRESPM), 32'd0);
      check("huge_dis_done_state", 32'(u_dis.state_q), 32'(DP_IDLE));

      // Zero-wait 4-beat burst to slot 0
      drive_addr(HTRANS_NONSEQ, 17'h00001, 1'b0, 32'h0000_0000);
      settle();
      check("burst_hsel", 32'(HSELS), 32'h00001);
      for (int b = 0; b < 4; b++) begin
         next_cycle();
         if (b < 3) drive_addr(HTRANS_SEQ, 17'h00001, 1'b0, 32'((b + 1) * 4));
         else       drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
         set_rdata(0, 32'hB000_0000 + 32'(b));
         settle();
         check($sformatf("burst_ready_%0d", b), 32'(HREADYM), 32'd1);
         check($sformatf("burst_rdata_%0d", b), HRDATAM, 32'hB000_0000 + 32'(b));
         check($sformatf("burst_state_%0d", b), 32'(u_dut.state_q), 32'(DP_SLAVE));
      end
      next_cycle();
      settle();
      check("burst_end_state", 32'(u_dut.state_q), 32'(DP_IDLE));

      // IDLE and BUSY never select a slot
      drive_addr(HTRANS_IDLE, 17'h00004, 1'b0, 32'h0000_2000);
      settle();
      check("idle_hsel", 32'(HSELS), 32'h0);
      next_cycle();
      drive_addr(HTRANS_BUSY, 17'h00004, 1'b0, 32'h0000_2000);
      settle();
      check("busy_hsel", 32'(HSELS), 32'h0);
      check("idle_ready", 32'(HREADYM), 32'd1);
      check("idle_resp", 32'(HRESPM), 32'd0);
      next_cycle();
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      settle();
      check("busy_state", 32'(u_dut.state_q), 32'(DP_IDLE));
      check("busy_ready", 32'(HREADYM), 32'd1);

      // Slave two-cycle ERROR on slot 1 passes through
      drive_addr(HTRANS_NONSEQ, 17'h00002, 1'b0, 32'h0000_1000);
      next_cycle();
      drive_addr(HTRANS_IDLE, '0, 1'b0, 32'h0);
      HREADYOUTS[1] = 1'b0;
      HRESPS[1] = 1'b1;
      settle();
      check("s1_err1_ready", 32'(HREADYM), 32'd0);
      check("s1_err1_resp", 32'(HRESPM), 32'd1);
      next_cycle();
      HREADYOUTS[1] = 1'b1;
      settle();
      check("s1_err2_ready", 32'(HREADYM), 32'd1);
      check("s1_err2_resp", 32'(HRESPM), 32'd1);
      next_cycle();
      HRESPS[1] = 1'b0;
      settle();
      check("s1_after_resp", 32'(HRESPM), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
